// File: rtl/rs_pkg.sv
// Shared definitions for the receive reconciliation sublayer.
// Holds the XGMII control characters, the sequence ordered-set codes, the
// link_fault encoding, the 32-bit assembly phase type and the column decode
// helpers used by the top level.
package rs_pkg;

    // XGMII control characters
    localparam logic [7:0] IDLE  = 8'h07;
    localparam logic [7:0] START = 8'hFB;
    localparam logic [7:0] TERM  = 8'hFD;
    localparam logic [7:0] SEQ   = 8'h9C;
    localparam logic [7:0] ERROR = 8'hFE;

    // Lane-3 codes carried by a sequence ordered set
    localparam logic [7:0] SEQ_LOCAL   = 8'h01;
    localparam logic [7:0] SEQ_REMOTE  = 8'h02;
    localparam logic [7:0] SEQ_LINKINT = 8'h03;

    // One full idle column (four lanes of 07, all control flags set)
    localparam logic [31:0] IDLE_COL_D = {IDLE, IDLE, IDLE, IDLE};
    localparam logic [3:0]  IDLE_COL_C = 4'hF;

    // link_fault encoding; values match the lane-3 sequence codes
    typedef enum logic [1:0] {
        LF_OK      = 2'b00,
        LF_LOCAL   = 2'b01,
        LF_REMOTE  = 2'b10,
        LF_LINKINT = 2'b11
    } link_fault_e;

    // 32-bit assembly phase: which half of the 64-bit word comes next
    typedef enum logic {
        PH0 = 1'b0,
        PH1 = 1'b1
    } phase_e;

    // True when a 4-lane column is a sequence ordered set
    function automatic logic col_is_seq(input logic [31:0] d, input logic [3:0] c);
        logic code_ok_s;
        code_ok_s = (d[31:24] == SEQ_LOCAL) || (d[31:24] == SEQ_REMOTE) ||
                    (d[31:24] == SEQ_LINKINT);
        return (d[7:0] == SEQ) && (c == 4'b0001) && (d[23:8] == 16'h0000) && code_ok_s;
    endfunction

    // Fault class of a column; only meaningful when col_is_seq() is true
    function automatic link_fault_e col_seq_type(input logic [31:0] d);
        link_fault_e t_s;
        case (d[25:24])
            2'b01:   t_s = LF_LOCAL;
            2'b10:   t_s = LF_REMOTE;
            2'b11:   t_s = LF_LINKINT;
            default: t_s = LF_OK;
        endcase
        return t_s;
    endfunction

endpackage

// File: rtl/rx_rs_fault_fsm.sv
// Receive fault state machine.
// Processes up to two columns per clock (column 0 first, then column 1),
// counting same-type sequence ordered sets and the columns between them.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   col0_v/col1_v       column strobes (col1_v tied low in 32-bit mode)
//   col0_seq/col1_seq   column is a sequence ordered set
//   col0_type/col1_type fault class of that sequence (link_fault encoding)
//   link_fault          registered fault status
//   link_fault_nxt      value link_fault takes at the next edge
//   seq_cnt             registered same-type sequence count
module rx_rs_fault_fsm
    import rs_pkg::*;
#(
    parameter int FAULT_THRESH = 4,
    parameter int FAULT_WIN    = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       col0_v,
    input  logic       col0_seq,
    input  logic [1:0] col0_type,
    input  logic       col1_v,
    input  logic       col1_seq,
    input  logic [1:0] col1_type,
    output logic [1:0] link_fault,
    output logic [1:0] link_fault_nxt,
    output logic [3:0] seq_cnt
);

    localparam int            CW       = $clog2(FAULT_WIN + 1);
    localparam logic [3:0]    THRESH_C = 4'(FAULT_THRESH);
    localparam logic [CW-1:0] WIN_C    = CW'(FAULT_WIN);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [1:0]      type_r, type_s;
    logic [3:0]      seq_cnt_r, seq_cnt_s;
    logic [CW-1:0]   col_cnt_r, col_cnt_s;
    logic [1:0]      link_fault_r, link_fault_s;
    logic [1:0]      v_s, q_s;
    logic [1:0][1:0] t_s;

    // Next-state: walk the columns in arrival order so two sequences in one word both count
    always_comb begin
        type_s       = type_r;
        seq_cnt_s    = seq_cnt_r;
        col_cnt_s    = col_cnt_r;
        link_fault_s = link_fault_r;
        v_s          = {col1_v, col0_v};
        q_s          = {col1_seq, col0_seq};
        t_s          = {col1_type, col0_type};
        for (int i = 0; i < 2; i++) begin
            if (v_s[i]) begin
                if (q_s[i]) begin
                    // A saturated col_cnt means the gap exceeded the window: restart
                    if ((t_s[i] == type_s) && (col_cnt_s < WIN_C)) begin
                        if (seq_cnt_s < THRESH_C) begin
                            seq_cnt_s = seq_cnt_s + 4'd1;
                        end else begin
                            seq_cnt_s = seq_cnt_s;
                        end
                    end else begin
                        type_s    = t_s[i];
                        seq_cnt_s = 4'd1;
                    end
                    col_cnt_s = '0;
                    if (seq_cnt_s == THRESH_C) begin
                        link_fault_s = type_s;
                    end else begin
                        link_fault_s = link_fault_s;
                    end
                end else begin
                    if (col_cnt_s < WIN_C) begin
                        col_cnt_s = col_cnt_s + ONE_C;
                    end else begin
                        col_cnt_s = col_cnt_s;
                    end
                    if (col_cnt_s == WIN_C) begin
                        link_fault_s = LF_OK;
                        seq_cnt_s    = 4'd0;
                    end else begin
                        link_fault_s = link_fault_s;
                    end
                end
            end else begin
                col_cnt_s = col_cnt_s;
            end
        end
    end

    // State register for type, counters and fault status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_r       <= LF_OK;
            seq_cnt_r    <= 4'd0;
            col_cnt_r    <= '0;
            link_fault_r <= LF_OK;
        end else begin
            type_r       <= type_s;
            seq_cnt_r    <= seq_cnt_s;
            col_cnt_r    <= col_cnt_s;
            link_fault_r <= link_fault_s;
        end
    end

    assign link_fault     = link_fault_r;
    assign link_fault_nxt = link_fault_s;
    assign seq_cnt        = seq_cnt_r;

endmodule

// File: rtl/rx_rs_layer_param.sv
// Receive reconciliation sublayer, parametrised for 32- or 64-bit SDR input.
// Assembles columns into 64-bit/8-control words, realigns on a Start in the
// upper half (32-bit mode), runs the fault FSM and replaces data with Idle
// while a fault is active.
// Ports:
//   rxclk, reset        clock and asynchronous active-low reset
//   rxd_in, rxc_in      input data/control, lane 0 in the low byte
//   rxd64, rxc8         assembled (and fault-gated) word
//   rxd64_valid         qualifier for rxd64/rxc8
//   link_fault          00 OK, 01 local, 10 remote, 11 link interruption
//   seq_cnt_o           current same-type sequence count
module rx_rs_layer_param
    import rs_pkg::*;
#(
    parameter int IN_W         = 32,
    parameter int FAULT_THRESH = 4,
    parameter int FAULT_WIN    = 128
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic [IN_W-1:0]   rxd_in,
    input  logic [IN_W/8-1:0] rxc_in,
    output logic [63:0]       rxd64,
    output logic [7:0]        rxc8,
    output logic              rxd64_valid,
    output logic [1:0]        link_fault,
    output logic [3:0]        seq_cnt_o
);

    logic [31:0] col0_d_s, col1_d_s;
    logic [3:0]  col0_c_s, col1_c_s;
    logic        col1_v_s;
    logic [63:0] asm_d_s;
    logic [7:0]  asm_c_s;
    logic        emit_s;
    logic [1:0]  lf_nxt_s;
    logic [63:0] rxd64_r;
    logic [7:0]  rxc8_r;
    logic        valid_r;

    if (IN_W == 64) begin : g_w64
        // Both columns arrive together; every cycle produces a word
        always_comb begin
            col0_d_s = rxd_in[31:0];
            col0_c_s = rxc_in[3:0];
            col1_d_s = rxd_in[63:32];
            col1_c_s = rxc_in[7:4];
            col1_v_s = 1'b1;
            asm_d_s  = rxd_in;
            asm_c_s  = rxc_in;
            emit_s   = 1'b1;
        end
    end else begin : g_w32
        phase_e      phase_r, phase_s;
        logic [31:0] hold_d_r, hold_d_s;
        logic [3:0]  hold_c_r, hold_c_s;
        logic        is_start_s;

        // Phase and held lower half registers
        always_ff @(posedge rxclk or negedge reset) begin
            if (!reset) begin
                phase_r  <= PH0;
                hold_d_r <= 32'h0000_0000;
                hold_c_r <= 4'h0;
            end else begin
                phase_r  <= phase_s;
                hold_d_r <= hold_d_s;
                hold_c_r <= hold_c_s;
            end
        end

        // Half-word assembly; a Start in the upper half flushes the held half padded with Idle
        always_comb begin
            col0_d_s   = rxd_in[31:0];
            col0_c_s   = rxc_in[3:0];
            col1_d_s   = 32'h0000_0000;
            col1_c_s   = 4'h0;
            col1_v_s   = 1'b0;
            is_start_s = (rxd_in[7:0] == START) && rxc_in[0];
            phase_s    = phase_r;
            hold_d_s   = hold_d_r;
            hold_c_s   = hold_c_r;
            asm_d_s    = {rxd_in[31:0], hold_d_r};
            asm_c_s    = {rxc_in[3:0], hold_c_r};
            emit_s     = 1'b0;
            case (phase_r)
                PH0: begin
                    hold_d_s = rxd_in[31:0];
                    hold_c_s = rxc_in[3:0];
                    phase_s  = PH1;
                end
                PH1: begin
                    emit_s = 1'b1;
                    if (is_start_s) begin
                        asm_d_s  = {IDLE_COL_D, hold_d_r};
                        asm_c_s  = {IDLE_COL_C, hold_c_r};
                        hold_d_s = rxd_in[31:0];
                        hold_c_s = rxc_in[3:0];
                        phase_s  = PH1;
                    end else begin
                        phase_s  = PH0;
                    end
                end
                default: begin
                    phase_s = PH0;
                end
            endcase
        end
    end

    rx_rs_fault_fsm #(
        .FAULT_THRESH (FAULT_THRESH),
        .FAULT_WIN    (FAULT_WIN)
    ) u_fault_fsm (
        .clk            (rxclk),
        .rst_n          (reset),
        .col0_v         (1'b1),
        .col0_seq       (col_is_seq(col0_d_s, col0_c_s)),
        .col0_type      (col_seq_type(col0_d_s)),
        .col1_v         (col1_v_s),
        .col1_seq       (col_is_seq(col1_d_s, col1_c_s)),
        .col1_type      (col_seq_type(col1_d_s)),
        .link_fault     (link_fault),
        .link_fault_nxt (lf_nxt_s),
        .seq_cnt        (seq_cnt_o)
    );

    // Output word register; the fault decision already includes the columns of this word
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            rxd64_r <= {IDLE_COL_D, IDLE_COL_D};
            rxc8_r  <= 8'hFF;
            valid_r <= 1'b0;
        end else begin
            valid_r <= emit_s;
            if (lf_nxt_s != LF_OK) begin
                rxd64_r <= {IDLE_COL_D, IDLE_COL_D};
                rxc8_r  <= 8'hFF;
            end else if (emit_s) begin
                rxd64_r <= asm_d_s;
                rxc8_r  <= asm_c_s;
            end else begin
                rxd64_r <= rxd64_r;
                rxc8_r  <= rxc8_r;
            end
        end
    end

    assign rxd64       = rxd64_r;
    assign rxc8        = rxc8_r;
    assign rxd64_valid = valid_r;

endmodule

// File: tb/tb_rx_rs_layer_param.sv
// Directed bench for rx_rs_layer_param: one 64-bit and one 32-bit instance,
// each driven from a table of {inputs, expected outputs} records, plus a
// hand-written asynchronous reset sequence on the 32-bit instance.
module tb_rx_rs_layer_param;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic [7:0]  rep;
        logic [63:0] ed;
        logic [7:0]  ec;
        logic        ev;
        logic [1:0]  elf;
        logic [3:0]  es;
    } vec_t;

    localparam logic [63:0] W_ID = 64'h0707070707070707;
    localparam logic [63:0] W_LS = 64'h07070707_0100009C;
    localparam logic [63:0] W_RS = 64'h07070707_0200009C;
    localparam logic [63:0] W_LL = 64'h0300009C_0300009C;
    localparam logic [63:0] W_PT = 64'h11223344_55667788;

    logic        clk;
    logic        rst64, rst32;
    logic [63:0] rxd64_in;
    logic [7:0]  rxc64_in;
    logic [31:0] rxd32_in;
    logic [3:0]  rxc32_in;
    logic [63:0] d64, d32;
    logic [7:0]  c64, c32;
    logic        v64, v32;
    logic [1:0]  lf64, lf32;
    logic [3:0]  s64, s32;
    logic [78:0] o64, o32;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tab64[17];
    vec_t tab32[12];

    rx_rs_layer_param #(.IN_W(64), .FAULT_THRESH(4), .FAULT_WIN(128)) dut64 (
        .rxclk(clk), .reset(rst64), .rxd_in(rxd64_in), .rxc_in(rxc64_in),
        .rxd64(d64), .rxc8(c64), .rxd64_valid(v64), .link_fault(lf64), .seq_cnt_o(s64)
    );

    rx_rs_layer_param #(.IN_W(32), .FAULT_THRESH(4), .FAULT_WIN(128)) dut32 (
        .rxclk(clk), .reset(rst32), .rxd_in(rxd32_in), .rxc_in(rxc32_in),
        .rxd64(d32), .rxc8(c32), .rxd64_valid(v32), .link_fault(lf32), .seq_cnt_o(s32)
    );

    assign o64 = {d64, c64, v64, lf64, s64};
    assign o32 = {d32, c32, v32, lf32, s32};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [63:0] d, input logic [7:0] c, input logic [7:0] rep,
                                input logic [63:0] ed, input logic [7:0] ec, input logic ev,
                                input logic [1:0] elf, input logic [3:0] es);
        vec_t v;
        v.d = d; v.c = c; v.rep = rep; v.ed = ed; v.ec = ec; v.ev = ev; v.elf = elf; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [78:0] act, input logic [78:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got d=%h c=%h v=%b lf=%b seq=%0d, expected d=%h c=%h v=%b lf=%b seq=%0d",
                     nm, act[78:15], act[14:7], act[6], act[5:4], act[3:0],
                     exp[78:15], exp[14:7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    initial begin
        // 64-bit: local fault, clear by window, remote after local, double link-interruption
        tab64[0]  = mk(W_LS, 8'hF1, 8'd1,  W_LS, 8'hF1, 1'b1, 2'b00, 4'd1);
        tab64[1]  = mk(W_LS, 8'hF1, 8'd1,  W_LS, 8'hF1, 1'b1, 2'b00, 4'd2);
        tab64[2]  = mk(W_LS, 8'hF1, 8'd1,  W_LS, 8'hF1, 1'b1, 2'b00, 4'd3);
        tab64[3]  = mk(W_LS, 8'hF1, 8'd1,  W_ID, 8'hFF, 1'b1, 2'b01, 4'd4);
        tab64[4]  = mk(W_ID, 8'hFF, 8'd63, W_ID, 8'hFF, 1'b1, 2'b01, 4'd4);
        tab64[5]  = mk(W_ID, 8'hFF, 8'd1,  W_ID, 8'hFF, 1'b1, 2'b00, 4'd0);
        tab64[6]  = mk(W_PT, 8'h00, 8'd1,  W_PT, 8'h00, 1'b1, 2'b00, 4'd0);
        tab64[7]  = mk(W_LS, 8'hF1, 8'd1,  W_LS, 8'hF1, 1'b1, 2'b00, 4'd1);
        tab64[8]  = mk(W_LS, 8'hF1, 8'd1,  W_LS, 8'hF1, 1'b1, 2'b00, 4'd2);
        tab64[9]  = mk(W_LS, 8'hF1, 8'd1,  W_LS, 8'hF1, 1'b1, 2'b00, 4'd3);
        tab64[10] = mk(W_RS, 8'hF1, 8'd1,  W_RS, 8'hF1, 1'b1, 2'b00, 4'd1);
        tab64[11] = mk(W_RS, 8'hF1, 8'd1,  W_RS, 8'hF1, 1'b1, 2'b00, 4'd2);
        tab64[12] = mk(W_RS, 8'hF1, 8'd1,  W_RS, 8'hF1, 1'b1, 2'b00, 4'd3);
        tab64[13] = mk(W_RS, 8'hF1, 8'd1,  W_ID, 8'hFF, 1'b1, 2'b10, 4'd4);
        tab64[14] = mk(W_LL, 8'h11, 8'd1,  W_ID, 8'hFF, 1'b1, 2'b10, 4'd2);
        tab64[15] = mk(W_LL, 8'h11, 8'd1,  W_ID, 8'hFF, 1'b1, 2'b11, 4'd4);
        tab64[16] = mk(W_LL, 8'h11, 8'd1,  W_ID, 8'hFF, 1'b1, 2'b11, 4'd4);

        // 32-bit: realign on Start at phase 1, then a local fault built column by column
        tab32[0]  = mk(64'h44332211, 8'h00, 8'd1, W_ID,                  8'hFF, 1'b0, 2'b00, 4'd0);
        tab32[1]  = mk(64'h555555FB, 8'h01, 8'd1, 64'h07070707_44332211, 8'hF0, 1'b1, 2'b00, 4'd0);
        tab32[2]  = mk(64'h88776655, 8'h00, 8'd1, 64'h88776655_555555FB, 8'h01, 1'b1, 2'b00, 4'd0);
        tab32[3]  = mk(64'h07070707, 8'h0F, 8'd1, 64'h88776655_555555FB, 8'h01, 1'b0, 2'b00, 4'd0);
        tab32[4]  = mk(64'h0D0C0B0A, 8'h00, 8'd1, 64'h0D0C0B0A_07070707, 8'h0F, 1'b1, 2'b00, 4'd0);
        tab32[5]  = mk(64'h0100009C, 8'h01, 8'd1, 64'h0D0C0B0A_07070707, 8'h0F, 1'b0, 2'b00, 4'd1);
        tab32[6]  = mk(64'h07070707, 8'h0F, 8'd1, W_LS,                  8'hF1, 1'b1, 2'b00, 4'd1);
        tab32[7]  = mk(64'h0100009C, 8'h01, 8'd1, W_LS,                  8'hF1, 1'b0, 2'b00, 4'd2);
        tab32[8]  = mk(64'h07070707, 8'h0F, 8'd1, W_LS,                  8'hF1, 1'b1, 2'b00, 4'd2);
        tab32[9]  = mk(64'h0100009C, 8'h01, 8'd1, W_LS,                  8'hF1, 1'b0, 2'b00, 4'd3);
        tab32[10] = mk(64'h07070707, 8'h0F, 8'd1, W_LS,                  8'hF1, 1'b1, 2'b00, 4'd3);
        tab32[11] = mk(64'h0100009C, 8'h01, 8'd1, W_ID,                  8'hFF, 1'b0, 2'b01, 4'd4);

        rst64 = 1'b0; rst32 = 1'b0;
        rxd64_in = W_ID; rxc64_in = 8'hFF;
        rxd32_in = 32'h07070707; rxc32_in = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset64", o64, {W_ID, 8'hFF, 1'b0, 2'b00, 4'd0});
        chk("reset32", o32, {W_ID, 8'hFF, 1'b0, 2'b00, 4'd0});

        rst64 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < int'(tab64[i].rep); r++) begin
                rxd64_in = tab64[i].d;
                rxc64_in = tab64[i].c;
                @(posedge clk);
                #1;
            end
            chk($sformatf("t64[%0d]", i), o64,
                {tab64[i].ed, tab64[i].ec, tab64[i].ev, tab64[i].elf, tab64[i].es});
        end

        rst32 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rxd32_in = tab32[i].d[31:0];
            rxc32_in = tab32[i].c[3:0];
            @(posedge clk);
            #1;
            chk($sformatf("t32[%0d]", i), o32,
                {tab32[i].ed, tab32[i].ec, tab32[i].ev, tab32[i].elf, tab32[i].es});
        end

        // Mid-cycle reset while in fault with a phase-0 half held
        rxd32_in = 32'h07070707; rxc32_in = 4'hF;
        #2;
        rst32 = 1'b0;
        #1;
        chk("rst32_async", o32, {W_ID, 8'hFF, 1'b0, 2'b00, 4'd0});
        @(posedge clk);
        #1;
        rst32 = 1'b1;
        rxd32_in = 32'h13121110; rxc32_in = 4'h0;
        @(posedge clk);
        #1;
        chk("post_rst_ph0", o32, {W_ID, 8'hFF, 1'b0, 2'b00, 4'd0});
        rxd32_in = 32'h17161514; rxc32_in = 4'h0;
        @(posedge clk);
        #1;
        chk("post_rst_word", o32, {64'h17161514_13121110, 8'h00, 1'b1, 2'b00, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_rs_layer_param.md
Name: rx_rs_layer_param

Overview:
Parametrised successor to the receive reconciliation-sublayer block. Runs on a single clock with SDR input, accepting 32- or 64-bit XGMII-style columns. Assembles the input into 64-bit/8-control words and detects sequence ordered sets. Runs the fault state machine in-line, with programmable threshold and window and an added link-interruption fault class, and replaces data with Idle while any fault is active.

Parameters:
IN_W, 32, input data width; legal values 32 or 64. rxc_in width is IN_W/8.
FAULT_THRESH, 4, number of same-type sequence ordered sets needed to declare a fault. Legal range 2..15.
FAULT_WIN, 128, columns without a sequence ordered set before the fault clears; also the maximum gap between counted sequences. Legal range 8..1023.

Ports:
rxclk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
rxd_in  in  IN_W  received data, lane 0 = bits [7:0]
rxc_in  in  IN_W/8  per-lane control flag
rxd64  out  64  assembled data, lanes 0-7
rxc8  out  8  assembled control flags
rxd64_valid  out  1  rxd64/rxc8 qualifier
link_fault  out  2  00 OK, 01 local, 10 remote, 11 link interruption
seq_cnt_o  out  4  current same-type sequence count (debug/verification)

Behaviour:
- Reset (reset=0, async): rxd64=64'h0707070707070707, rxc8=8'hFF, rxd64_valid=0, link_fault=00, seq_cnt_o=0, col_cnt=0, phase=0.
- Column: 4 lanes. A column is a sequence ordered set when all of the following hold:
  - lane0=8'h9C with its control flag set;
  - lanes 1-3 have control flag 0;
  - lanes 1-2 are 8'h00;
  - lane3 is in {01 local, 02 remote, 03 link interruption}.
  - Any other lane3 value is not a sequence ordered set.
- Assembly, IN_W=64:
  - one register stage, so output appears 1 cycle after input;
  - rxd64_valid=1 every cycle after reset release;
  - two columns per cycle, evaluated lower column first.
- Assembly, IN_W=32:
  - phase 0 column goes to lanes 0-3 and phase 1 column goes to lanes 4-7;
  - rxd64_valid pulses for 1 cycle, on the cycle after the phase-1 column;
  - realign: a column with lane0=8'hFB and its control flag set, arriving at phase 1, is placed as the phase-0 column. The held phase-0 half is emitted as lanes 0-3, with lanes 4-7 filled with Idle (07, ctrl 1) and valid asserted.
- Fault FSM (per column, in order): state holds {type, seq_cnt, col_cnt}.
  - Sequence of the same type as held type: seq_cnt saturates at FAULT_THRESH. Columns since the previous sequence must be ≤ FAULT_WIN; otherwise seq_cnt restarts at 1.
  - Sequence of a different type, or first sequence: type=new, seq_cnt=1.
  - Any sequence clears col_cnt to 0. A non-sequence column increments col_cnt, saturating at FAULT_WIN.
  - seq_cnt reaching FAULT_THRESH sets link_fault to the type code. This is visible in the same cycle as the corresponding rxd64 word.
  - col_cnt reaching FAULT_WIN sets link_fault=00 and seq_cnt=0.
  - A fault-type change while in fault: link_fault keeps the old code until the new type reaches FAULT_THRESH.
- Two sequences in one 64-bit word: both are counted sequentially, so seq_cnt can advance by 2 in one cycle.
- Data gating: while link_fault≠00 (registered value, including the update from the current word), rxd64=all 07 and rxc8=8'hFF. Valid timing is unchanged.
- Reset mid-operation: everything returns to reset values immediately. A partially assembled 32-bit word is discarded.
- Widths: col_cnt is clog2(FAULT_WIN+1) bits; seq_cnt is 4 bits.

Decomposition:
- Package rs_pkg holds:
  - control characters: IDLE 8'h07, START 8'hFB, TERM 8'hFD, SEQ 8'h9C, ERROR 8'hFE;
  - sequence codes 01/02/03;
  - the link_fault encoding as a typedef enum (LF_OK, LF_LOCAL, LF_REMOTE, LF_LINKINT).
- One sub-module, rx_rs_fault_fsm:
  - takes two column-valid strobes plus decoded sequence type and enable per column;
  - owns the counters and link_fault;
  - is instantiated once, with the second column strobe tied low in 32-bit mode.
- Assembly and gating stay in the top.

Test Plan:
1. IN_W=64, 4 local sequences (lane3=01) on consecutive cycles interleaved with idle → link_fault=01 after the 4th. rxd64 is all 07 from that word onward, and seq_cnt_o=4.
2. After (1), 128 idle columns → link_fault=00 on the column that makes col_cnt=128. Data passes through unmodified on the next word.
3. 3 local sequences then 4 remote sequences, each within 10 columns → link_fault stays 00 through the locals, seq_cnt_o resets to 1 on the first remote, and link_fault=10 after the 4th remote.
4. IN_W=32, Start column arriving at phase 1 → the preceding half-word is emitted with Idle in lanes 4-7 and valid=1. The Start column then appears in lanes 0-3 of the next valid word.
5. IN_W=64, a word carrying two link-interruption sequences, twice → link_fault=11 after the second word, and seq_cnt_o goes 2, then 4.
6. Assert reset mid-fault with IN_W=32 and the phase-0 half held → all outputs return to reset values asynchronously. The first valid after release comes from two fresh columns.
